scientific_alu: RTL and testbench
=================================

SCIENTIFIC_ALU -- requirements
Module: scientific_alu

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 a_in  input  64  operand A, IEEE-754 double bit pattern.
REQ-005 b_in  input  64  operand B, IEEE-754 double bit pattern.
REQ-006 opcode  input  4  operation select.
REQ-007 result_out  output  64  registered result, IEEE-754 double bit pattern.
REQ-008 excep  output  1  registered flag: floating-point exception (overflow/inf/NaN result from a valid domain).
REQ-009 err  output  1  registered flag: domain error (operation undefined for operands).

Function
REQ-010 Opcode map (A=a_in, B=b_in as reals):
- 0 pow(A,B); 1 sqrt(A); 2 exp(A); 3 ldexp = A*2^trunc(B); 4 abs(A); 5 fmod(A,B), sign of A;
- 6 ceil(A); 7 floor(A); 8 ln(A); 9 log10(A); A sin(A); B cos(A); C tan(A);
- D asin(A); E acos(A); F atan(A); angles in radians.
REQ-011 Latency 1: inputs sampled on rising clk; result_out/excep/err valid after that edge, held until next edge; no handshake, new op accepted every cycle.
REQ-012 Domain errors SHALL set err=1, excep=0, result_out=64'h7FF8_0000_0000_0000 (quiet NaN):
- sqrt A<0; ln/log10 A<=0; asin/acos |A|>1; fmod B==0; pow A<0 with non-integer B; pow A==0 with B<0.
REQ-013 Finite operands with infinite/NaN result (e.g. exp(1000), pow overflow) SHALL set excep=1, err=0, result_out = the computed IEEE value (+/-inf).
REQ-014 Any NaN or inf operand used by the opcode SHALL set excep=1, err=0, result_out=quiet NaN; B is ignored for single-operand opcodes.
REQ-015 Otherwise excep=0, err=0; flags are recomputed every cycle, never sticky.
REQ-016 Model is behavioral, simulation-only: conversion via $bitstoreal/$realtobits and IEEE 1364-2005 real math system functions; not intended for synthesis.

Reset
REQ-017 rst=1 at rising clk SHALL force result_out=64'h0 (+0.0), excep=0, err=0, overriding any operation in the same cycle.
REQ-018 First cycle after rst deasserts SHALL compute normally from the inputs sampled at that edge; no other internal state exists.

Structure
REQ-019 Shared package sci_alu_pkg: opcode enum/localparams (OP_POW..OP_ATAN), QNAN_BITS and ZERO_BITS constants.
REQ-020 One combinational sub-module sci_alu_compute (a, b, opcode -> result, excep, err); top scientific_alu holds only the output register and reset.

Verification
REQ-021 A=16.0, B=2.0, sweep opcode 0..F one per cycle -> results 256.0, 4.0, 8886110.52, 64.0, 16.0, 0.0, 16.0, 16.0, 2.77, 1.20, -0.29, -0.96, 0.30, NaN(err=1), NaN(err=1), 1.51 (2-decimal tolerance), each one cycle after opcode applied.
REQ-022 A=-4.0, opcode 1 -> err=1, excep=0, result_out=64'h7FF8000000000000; next cycle opcode 4 -> 4.0, err=0.
REQ-023 A=1000.0, opcode 2 -> excep=1, err=0, result_out=64'h7FF0000000000000.
REQ-024 A=7.5, B=0.0, opcode 5 -> err=1; B=2.0 -> 1.5, err=0.
REQ-025 Assert rst while opcode 0 with A=16, B=2 -> next edge result_out=0, flags 0; release -> 256.0 one cycle later.

Source files
------------

// File: rtl/sci_alu_pkg.sv
// Shared opcode encoding, IEEE-754 constants and helpers for the scientific ALU.
// Behavioral real-math model; no latency or flow control of its own.
package sci_alu_pkg;

  typedef enum logic [3:0] {
    OP_POW   = 4'h0,
    OP_SQRT  = 4'h1,
    OP_EXP   = 4'h2,
    OP_LDEXP = 4'h3,
    OP_ABS   = 4'h4,
    OP_FMOD  = 4'h5,
    OP_CEIL  = 4'h6,
    OP_FLOOR = 4'h7,
    OP_LN    = 4'h8,
    OP_LOG10 = 4'h9,
    OP_SIN   = 4'hA,
    OP_COS   = 4'hB,
    OP_TAN   = 4'hC,
    OP_ASIN  = 4'hD,
    OP_ACOS  = 4'hE,
    OP_ATAN  = 4'hF
  } op_e;

  localparam logic [63:0] QNAN_BITS = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] ZERO_BITS = 64'h0000_0000_0000_0000;

  // All-ones exponent covers both infinities and every NaN.
  function automatic logic is_nonfinite(input logic [63:0] bits);
    return bits[62:52] == 11'h7FF;
  endfunction

  function automatic logic uses_b(input op_e op);
    return op inside {OP_POW, OP_LDEXP, OP_FMOD};
  endfunction

  function automatic real trunc_r(input real x);
    return (x < 0.0) ? $ceil(x) : $floor(x);
  endfunction

endpackage

// File: rtl/sci_alu_compute.sv
// Combinational evaluation of one opcode on two IEEE doubles, with domain/exception flags.
// Zero latency, no backpressure; the caller registers the outputs.
module sci_alu_compute
  import sci_alu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  opcode,
  output logic [63:0] result,
  output logic        excep,
  output logic        err
);

  op_e         w_op;
  real         w_a;
  real         w_b;
  real         w_val;
  logic [63:0] w_bits;
  logic        w_dom_err;

  always_comb begin
    w_op      = op_e'(opcode);
    w_a       = $bitstoreal(a);
    w_b       = $bitstoreal(b);
    w_val     = 0.0;
    w_dom_err = 1'b0;
    case (w_op)
      OP_POW: begin
        w_dom_err = ((w_a < 0.0) && ($floor(w_b) != w_b)) || ((w_a == 0.0) && (w_b < 0.0));
        w_val     = $pow(w_a, w_b);
      end
      OP_SQRT: begin
        w_dom_err = (w_a < 0.0);
        w_val     = $sqrt(w_a);
      end
      OP_EXP:   w_val = $exp(w_a);
      OP_LDEXP: w_val = w_a * $pow(2.0, trunc_r(w_b));
      OP_ABS:   w_val = (w_a < 0.0) ? -w_a : w_a;
      OP_FMOD: begin
        w_dom_err = (w_b == 0.0);
        if (!w_dom_err) begin
          w_val = w_a - w_b * trunc_r(w_a / w_b);
          // A zero remainder still carries the sign of the dividend.
          if (w_val == 0.0) w_val = (w_a < 0.0) ? -0.0 : 0.0;
        end
      end
      OP_CEIL:  w_val = $ceil(w_a);
      OP_FLOOR: w_val = $floor(w_a);
      OP_LN: begin
        w_dom_err = (w_a <= 0.0);
        if (!w_dom_err) w_val = $ln(w_a);
      end
      OP_LOG10: begin
        w_dom_err = (w_a <= 0.0);
        if (!w_dom_err) w_val = $log10(w_a);
      end
      OP_SIN:   w_val = $sin(w_a);
      OP_COS:   w_val = $cos(w_a);
      OP_TAN:   w_val = $tan(w_a);
      OP_ASIN: begin
        w_dom_err = (w_a > 1.0) || (w_a < -1.0);
        if (!w_dom_err) w_val = $asin(w_a);
      end
      OP_ACOS: begin
        w_dom_err = (w_a > 1.0) || (w_a < -1.0);
        if (!w_dom_err) w_val = $acos(w_a);
      end
      OP_ATAN:  w_val = $atan(w_a);
      default:  w_val = 0.0;
    endcase

    w_bits = $realtobits(w_val);
    result = w_bits;
    excep  = 1'b0;
    err    = 1'b0;
    // Non-finite operands take priority over any domain check on their value.
    if (is_nonfinite(a) || (uses_b(w_op) && is_nonfinite(b))) begin
      result = QNAN_BITS;
      excep  = 1'b1;
    end else if (w_dom_err) begin
      result = QNAN_BITS;
      err    = 1'b1;
    end else if (is_nonfinite(w_bits)) begin
      excep  = 1'b1;
    end
  end

endmodule

// File: rtl/scientific_alu.sv
// Scientific ALU top: registers the combinational result and flags, one-cycle latency.
// Accepts a new operation every cycle; no handshake, synchronous reset clears outputs.
module scientific_alu
  import sci_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a_in,
  input  logic [63:0] b_in,
  input  logic [3:0]  opcode,
  output logic [63:0] result_out,
  output logic        excep,
  output logic        err
);

  logic [63:0] w_result;
  logic        w_excep;
  logic        w_err;
  logic [63:0] r_result;
  logic        r_excep;
  logic        r_err;

  sci_alu_compute u_compute (
    .a      (a_in),
    .b      (b_in),
    .opcode (opcode),
    .result (w_result),
    .excep  (w_excep),
    .err    (w_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= ZERO_BITS;
      r_excep  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_result <= w_result;
      r_excep  <= w_excep;
      r_err    <= w_err;
    end
  end

  assign result_out = r_result;
  assign excep      = r_excep;
  assign err        = r_err;

endmodule

// File: tb/tb_scientific_alu.sv
// Self-checking bench for scientific_alu: scoreboard of expected results, one cycle latency.
module tb_scientific_alu;

  localparam real         TOL  = 0.01;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] PINF = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF = 64'hFFF0_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [3:0]  opcode;
  logic [63:0] result_out;
  logic        excep;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  // Pending stimulus and the expectations pushed alongside it when driven.
  logic [63:0] s_a[$];
  logic [63:0] s_b[$];
  logic [3:0]  s_op[$];
  bit          s_exact[$];
  logic [63:0] s_bits[$];
  real         s_val[$];
  logic [1:0]  s_flg[$];
  string       s_name[$];

  logic [63:0] q_bits[$];
  bit          q_exact[$];
  real         q_val[$];
  logic [1:0]  q_flg[$];
  string       q_name[$];

  scientific_alu dut (
    .clk        (clk),
    .rst        (rst),
    .a_in       (a_in),
    .b_in       (b_in),
    .opcode     (opcode),
    .result_out (result_out),
    .excep      (excep),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                     input bit exact, input logic [63:0] bits, input real val,
                     input logic [1:0] flg, input string nm);
    s_a.push_back(a);  s_b.push_back(b);  s_op.push_back(op);
    s_exact.push_back(exact); s_bits.push_back(bits); s_val.push_back(val);
    s_flg.push_back(flg); s_name.push_back(nm);
  endtask

  // Drives the next pending vector and moves its expectation into the scoreboard.
  task automatic drive_next();
    a_in   = s_a.pop_front();
    b_in   = s_b.pop_front();
    opcode = s_op.pop_front();
    q_exact.push_back(s_exact.pop_front());
    q_bits.push_back(s_bits.pop_front());
    q_val.push_back(s_val.pop_front());
    q_flg.push_back(s_flg.pop_front());
    q_name.push_back(s_name.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in = $realtobits(16.0); b_in = $realtobits(2.0); opcode = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (result_out !== 64'h0) $display("FAIL reset_result: got %h want %h", result_out, 64'h0);
    else n_pass++;
    n_checks++;
    if ({excep, err} !== 2'b00) $display("FAIL reset_flags: got excep=%b err=%b want 0 0", excep, err);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_opcode_sweep();
    real exp_v[16];
    logic [63:0] e_bits;
    logic [1:0]  e_flg;
    real         e_val, got;
    bit          e_exact, bad;
    string       e_name;
    exp_v = '{256.0, 4.0, 8886110.52, 64.0, 16.0, 0.0, 16.0, 16.0,
              2.77, 1.20, -0.29, -0.96, 0.30, 0.0, 0.0, 1.51};
    for (int i = 0; i < 16; i++) begin
      if (i == 13 || i == 14)
        add($realtobits(16.0), $realtobits(2.0), 4'(i), 1'b1, QNAN, 0.0, 2'b01, $sformatf("sweep_op%0d", i));
      else
        add($realtobits(16.0), $realtobits(2.0), 4'(i), 1'b0, 64'h0, exp_v[i], 2'b00, $sformatf("sweep_op%0d", i));
    end
    while (s_a.size() > 0) begin
      drive_next();
      @(posedge clk); #1;
      e_exact = q_exact.pop_front(); e_bits = q_bits.pop_front(); e_val = q_val.pop_front();
      e_flg = q_flg.pop_front(); e_name = q_name.pop_front();
      got = $bitstoreal(result_out);
      if (e_exact) bad = (result_out !== e_bits);
      else bad = (result_out[62:52] == 11'h7FF) || (((got > e_val) ? got - e_val : e_val - got) > TOL);
      n_checks++;
      if (bad) $display("FAIL %s result: got %h (%f) want %h (%f)", e_name, result_out, got, e_bits, e_val);
      else n_pass++;
      n_checks++;
      if ({excep, err} !== e_flg)
        $display("FAIL %s flags: got excep=%b err=%b want excep=%b err=%b", e_name, excep, err, e_flg[1], e_flg[0]);
      else n_pass++;
    end
  endtask

  task automatic test_domain_errors();
    logic [63:0] e_bits;
    logic [1:0]  e_flg;
    real         e_val, got;
    bit          e_exact, bad;
    string       e_name;
    add($realtobits(-4.0), $realtobits(0.0),  4'h1, 1'b1, QNAN, 0.0, 2'b01, "sqrt_neg");
    add($realtobits(-4.0), $realtobits(0.0),  4'h4, 1'b1, $realtobits(4.0), 0.0, 2'b00, "abs_after_err");
    add($realtobits(7.5),  $realtobits(0.0),  4'h5, 1'b1, QNAN, 0.0, 2'b01, "fmod_b0");
    add($realtobits(7.5),  $realtobits(2.0),  4'h5, 1'b1, $realtobits(1.5), 0.0, 2'b00, "fmod_pos");
    add($realtobits(-7.5), $realtobits(2.0),  4'h5, 1'b1, $realtobits(-1.5), 0.0, 2'b00, "fmod_neg");
    add($realtobits(0.0),  $realtobits(0.0),  4'h8, 1'b1, QNAN, 0.0, 2'b01, "ln_zero");
    add($realtobits(-1.0), $realtobits(0.0),  4'h9, 1'b1, QNAN, 0.0, 2'b01, "log10_neg");
    add($realtobits(1.5),  $realtobits(0.0),  4'hD, 1'b1, QNAN, 0.0, 2'b01, "asin_gt1");
    add($realtobits(-2.0), $realtobits(0.0),  4'hE, 1'b1, QNAN, 0.0, 2'b01, "acos_ltm1");
    add($realtobits(1.0),  $realtobits(0.0),  4'hE, 1'b1, $realtobits(0.0), 0.0, 2'b00, "acos_one");
    add($realtobits(-2.0), $realtobits(0.5),  4'h0, 1'b1, QNAN, 0.0, 2'b01, "pow_neg_frac");
    add($realtobits(0.0),  $realtobits(-1.0), 4'h0, 1'b1, QNAN, 0.0, 2'b01, "pow_zero_negexp");
    add($realtobits(-2.0), $realtobits(3.0),  4'h0, 1'b1, $realtobits(-8.0), 0.0, 2'b00, "pow_neg_int");
    while (s_a.size() > 0) begin
      drive_next();
      @(posedge clk); #1;
      e_exact = q_exact.pop_front(); e_bits = q_bits.pop_front(); e_val = q_val.pop_front();
      e_flg = q_flg.pop_front(); e_name = q_name.pop_front();
      got = $bitstoreal(result_out);
      if (e_exact) bad = (result_out !== e_bits);
      else bad = (((got > e_val) ? got - e_val : e_val - got) > TOL);
      n_checks++;
      if (bad) $display("FAIL %s result: got %h want %h", e_name, result_out, e_bits);
      else n_pass++;
      n_checks++;
      if ({excep, err} !== e_flg)
        $display("FAIL %s flags: got excep=%b err=%b want excep=%b err=%b", e_name, excep, err, e_flg[1], e_flg[0]);
      else n_pass++;
    end
  endtask

  task automatic test_fp_exceptions();
    logic [63:0] e_bits;
    logic [1:0]  e_flg;
    string       e_name;
    add($realtobits(1000.0),  $realtobits(0.0),    4'h2, 1'b1, PINF, 0.0, 2'b10, "exp_overflow");
    add($realtobits(10.0),    $realtobits(400.0),  4'h0, 1'b1, PINF, 0.0, 2'b10, "pow_overflow");
    add($realtobits(-10.0),   $realtobits(401.0),  4'h0, 1'b1, NINF, 0.0, 2'b10, "pow_neg_overflow");
    add($realtobits(1.0e308), $realtobits(2000.0), 4'h3, 1'b1, PINF, 0.0, 2'b10, "ldexp_overflow");
    add(QNAN,                 $realtobits(0.0),    4'h1, 1'b1, QNAN, 0.0, 2'b10, "sqrt_nan_a");
    add(PINF,                 $realtobits(0.0),    4'h2, 1'b1, QNAN, 0.0, 2'b10, "exp_inf_a");
    add($realtobits(2.0),     PINF,                4'h0, 1'b1, QNAN, 0.0, 2'b10, "pow_inf_b");
    add($realtobits(7.5),     QNAN,                4'h5, 1'b1, QNAN, 0.0, 2'b10, "fmod_nan_b");
    add($realtobits(-3.5),    PINF,                4'h4, 1'b1, $realtobits(3.5), 0.0, 2'b00, "abs_ignores_b");
    add($realtobits(3.0),     $realtobits(2.7),    4'h3, 1'b1, $realtobits(12.0), 0.0, 2'b00, "ldexp_trunc_pos");
    add($realtobits(3.0),     $realtobits(-2.7),   4'h3, 1'b1, $realtobits(0.75), 0.0, 2'b00, "ldexp_trunc_neg");
    add($realtobits(-2.5),    $realtobits(0.0),    4'h6, 1'b1, $realtobits(-2.0), 0.0, 2'b00, "ceil_neg");
    add($realtobits(-2.5),    $realtobits(0.0),    4'h7, 1'b1, $realtobits(-3.0), 0.0, 2'b00, "floor_neg");
    while (s_a.size() > 0) begin
      drive_next();
      @(posedge clk); #1;
      void'(q_exact.pop_front()); void'(q_val.pop_front());
      e_bits = q_bits.pop_front(); e_flg = q_flg.pop_front(); e_name = q_name.pop_front();
      n_checks++;
      if (result_out !== e_bits) $display("FAIL %s result: got %h want %h", e_name, result_out, e_bits);
      else n_pass++;
      n_checks++;
      if ({excep, err} !== e_flg)
        $display("FAIL %s flags: got excep=%b err=%b want excep=%b err=%b", e_name, excep, err, e_flg[1], e_flg[0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_override();
    logic [63:0] want256;
    want256 = $realtobits(256.0);
    a_in = $realtobits(16.0); b_in = $realtobits(2.0); opcode = 4'h0; rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (result_out !== want256) $display("FAIL pre_reset_pow: got %h want %h", result_out, want256);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (result_out !== 64'h0) $display("FAIL reset_override_result: got %h want %h", result_out, 64'h0);
    else n_pass++;
    n_checks++;
    if ({excep, err} !== 2'b00) $display("FAIL reset_override_flags: got excep=%b err=%b want 0 0", excep, err);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (result_out !== want256) $display("FAIL post_reset_pow: got %h want %h", result_out, want256);
    else n_pass++;
    n_checks++;
    if ({excep, err} !== 2'b00) $display("FAIL post_reset_flags: got excep=%b err=%b want 0 0", excep, err);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; a_in = 64'h0; b_in = 64'h0; opcode = 4'h0;
    test_reset();
    test_opcode_sweep();
    test_domain_errors();
    test_fp_exceptions();
    test_reset_override();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
